matrix_mem_ctrl: RTL and testbench

MATRIX_MEM_CTRL -- requirements
Module: matrix_mem_ctrl

---
 rtl/matrix_mem_ctrl_if.sv | 51 +++++
 rtl/matrix_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_matrix_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mem_ctrl_if.sv
// Bus bundle for matrix_mem_ctrl: command handshake, RAM port, op unit.
// verify_err is present only when WRITE_VERIFY_EN is defined.
interface matrix_mem_ctrl_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_c;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] op_result;
`ifdef WRITE_VERIFY_EN
  logic              verify_err;

  modport master (
    input  start, addr_a, addr_b, addr_c,
    input  mem_rdata, op_result,
    output busy, done, mem_addr, mem_wren,
    output mem_wdata, op_a, op_b, verify_err
  );

  modport slave (
    output start, addr_a, addr_b, addr_c,
    output mem_rdata, op_result,
    input  busy, done, mem_addr, mem_wren,
    input  mem_wdata, op_a, op_b, verify_err
  );
`else
  modport master (
    input  start, addr_a, addr_b, addr_c,
    input  mem_rdata, op_result,
    output busy, done, mem_addr, mem_wren,
    output mem_wdata, op_a, op_b
  );

  modport slave (
    output start, addr_a, addr_b, addr_c,
    output mem_rdata, op_result,
    input  busy, done, mem_addr, mem_wren,
    input  mem_wdata, op_a, op_b
  );
`endif
endinterface

// File: rtl/matrix_mem_ctrl.sv
// Sequences read A, read B, execute, write C against a single-port RAM.
// Optional WRITE_VERIFY_EN adds a readback compare after the write.
module matrix_mem_ctrl #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 8
) (
  input logic               clk,
  input logic               reset,
  matrix_mem_ctrl_if.master bus
);

`ifdef WRITE_VERIFY_EN
  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, CAP_B, EXEC, WR, DONE, VRD, VCHK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_B, EXEC, WR, DONE
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_c_q, addr_c_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
`ifdef WRITE_VERIFY_EN
  logic              verr_q, verr_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
`ifdef WRITE_VERIFY_EN
    verr_d   = verr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_a_d = bus.addr_a;
          addr_b_d = bus.addr_b;
          addr_c_d = bus.addr_c;
          state_d  = RD_A;
`ifdef WRITE_VERIFY_EN
          verr_d   = 1'b0;
`endif
        end
      end
      RD_A:  state_d = RD_B;
      RD_B: begin
        op_a_d  = bus.mem_rdata;
        state_d = CAP_B;
      end
      CAP_B: begin
        op_b_d  = bus.mem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = bus.op_result;
        state_d = WR;
      end
`ifdef WRITE_VERIFY_EN
      WR:    state_d = VRD;
      VRD:   state_d = VCHK;
      VCHK: begin
        if (bus.mem_rdata != res_q) verr_d = 1'b1;
        state_d = DONE;
      end
`else
      WR:    state_d = DONE;
`endif
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they arrive registered.
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    wren_d     = (state_d == WR);
    mem_addr_d = '0;
    unique case (1'b1)
      (state_d == RD_A): mem_addr_d = addr_a_d;
      (state_d == RD_B): mem_addr_d = addr_b_q;
`ifdef WRITE_VERIFY_EN
      (state_d == WR),
      (state_d == VRD):  mem_addr_d = addr_c_q;
`else
      (state_d == WR):   mem_addr_d = addr_c_q;
`endif
      default:           mem_addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_c_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wren_q     <= 1'b0;
`ifdef WRITE_VERIFY_EN
      verr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_c_q   <= addr_c_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wren_q     <= wren_d;
`ifdef WRITE_VERIFY_EN
      verr_q     <= verr_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wren  = wren_q;
  assign bus.mem_wdata = res_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
`ifdef WRITE_VERIFY_EN
  assign bus.verify_err = verr_q;
`endif

endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Directed bench for matrix_mem_ctrl with a behavioural RAM and an adder.
// Works with and without WRITE_VERIFY_EN.
module tb_matrix_mem_ctrl;
  localparam int DW = 256;
  localparam int AW = 8;
`ifdef WRITE_VERIFY_EN
  localparam int DONE_CYC = 8;
`else
  localparam int DONE_CYC = 6;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matrix_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  matrix_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] ram [256];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic          corrupt = 1'b0;
  int            wr_count = 0;
  logic [AW-1:0] last_wr = '0;

  assign bus.op_result = bus.op_a + bus.op_b;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    if (bus.mem_wren) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
      last_wr  <= bus.mem_addr;
    end
    if (corrupt && bus.mem_addr == 8'd2)
      bus.mem_rdata <= ram[bus.mem_addr] ^ {{(DW-1){1'b0}}, 1'b1};
    else
      bus.mem_rdata <= ram[bus.mem_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  // Issue one pulse of start, return the cycle in which done was seen.
  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] c, output int dc);
    int k;
    bus.addr_a = a;
    bus.addr_b = b;
    bus.addr_c = c;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 1;
    while (!bus.done && k < 20) begin
      tick();
      k++;
    end
    dc = bus.done ? k : -1;
    tick();
  endtask

  logic [DW-1:0] b01, b02, b03, b10, b20, b30;
  int dc, w0, busy_cnt, k;

  initial begin
    b01 = {32{8'h01}};
    b02 = {32{8'h02}};
    b03 = {32{8'h03}};
    b10 = {32{8'h10}};
    b20 = {32{8'h20}};
    b30 = {32{8'h30}};
    bus.start = 1'b0;
    bus.addr_a = '0;
    bus.addr_b = '0;
    bus.addr_c = '0;

    preload(8'd0, b01);
    preload(8'd1, b02);
    preload(8'd2, '0);
    preload(8'd3, '0);
    preload(8'd4, '0);
    preload(8'd5, b10);
    preload(8'd6, b20);

    chk("rst_busy", DW'(bus.busy), '0);
    chk("rst_done", DW'(bus.done), '0);
    chk("rst_wren", DW'(bus.mem_wren), '0);
    chk("rst_addr", DW'(bus.mem_addr), '0);
    chk("rst_op_a", bus.op_a, '0);
    chk("rst_op_b", bus.op_b, '0);
    chk("rst_wdata", bus.mem_wdata, '0);
`ifdef WRITE_VERIFY_EN
    chk("rst_verr", DW'(bus.verify_err), '0);
`endif
    reset = 1'b0;
    tick();
    chk("idle_busy", DW'(bus.busy), '0);

    // Basic add: RAM[2] = RAM[0] + RAM[1]
    w0 = wr_count;
    run_op(8'd0, 8'd1, 8'd2, dc);
    chk("t1_done_cyc", DW'(dc), DW'(DONE_CYC));
    chk("t1_busy_after", DW'(bus.busy), '0);
    chk("t1_ram2", ram[2], b03);
    chk("t1_wr_cnt", DW'(wr_count - w0), DW'(1));
    chk("t1_wr_addr", DW'(last_wr), DW'(2));
    chk("t1_op_a", bus.op_a, b01);
    chk("t1_op_b", bus.op_b, b02);
    chk("t1_wdata", bus.mem_wdata, b03);
`ifdef WRITE_VERIFY_EN
    chk("t1_verr", DW'(bus.verify_err), '0);
`endif

    // start pulses while busy (cycle 2 and DONE) are ignored
    w0 = wr_count;
    bus.addr_a = 8'd0;
    bus.addr_b = 8'd1;
    bus.addr_c = 8'd3;
    bus.start = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 1; i <= DONE_CYC; i++) begin
      bus.start = (i == 2 || i == DONE_CYC);
      busy_cnt += int'(bus.busy);
      if (i == DONE_CYC) chk("t2_done", DW'(bus.done), DW'(1));
      tick();
    end
    bus.start = 1'b0;
    chk("t2_idle1", DW'(bus.busy), '0);
    tick();
    chk("t2_idle2", DW'(bus.busy), '0);
    chk("t2_busy_cnt", DW'(busy_cnt), DW'(DONE_CYC));
    chk("t2_wr_cnt", DW'(wr_count - w0), DW'(1));
    chk("t2_ram3", ram[3], b03);

    // Reset in CAP_B aborts the operation before any write
    w0 = wr_count;
    bus.addr_a = 8'd0;
    bus.addr_b = 8'd1;
    bus.addr_c = 8'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("t3_capb_op_a", bus.op_a, b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_busy", DW'(bus.busy), '0);
    chk("t3_op_a", bus.op_a, '0);
    chk("t3_addr", DW'(bus.mem_addr), '0);
    repeat (10) tick();
    chk("t3_wr_cnt", DW'(wr_count - w0), '0);
    chk("t3_ram4", ram[4], '0);

    // start held high: back-to-back ops, addresses changed mid-op
    preload(8'd2, '0);
    preload(8'd3, '0);
    w0 = wr_count;
    bus.addr_a = 8'd1;
    bus.addr_b = 8'd0;
    bus.addr_c = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.addr_c = 8'd3;
    repeat (DONE_CYC - 1) tick();
    chk("t4_done1", DW'(bus.done), DW'(1));
    tick();
    chk("t4_gap_busy", DW'(bus.busy), '0);
    tick();
    chk("t4_rda_busy", DW'(bus.busy), DW'(1));
    chk("t4_rda_addr", DW'(bus.mem_addr), DW'(1));
    bus.start = 1'b0;
    k = 1;
    while (!bus.done && k < 20) begin
      tick();
      k++;
    end
    chk("t4_done2_cyc", DW'(k), DW'(DONE_CYC));
    tick();
    chk("t4_ram2", ram[2], b03);
    chk("t4_ram3", ram[3], b03);
    chk("t4_wr_cnt", DW'(wr_count - w0), DW'(2));

    // Result address aliases operand A
    run_op(8'd5, 8'd6, 8'd5, dc);
    chk("t5_done_cyc", DW'(dc), DW'(DONE_CYC));
    chk("t5_ram5", ram[5], b30);
    chk("t5_op_a", bus.op_a, b10);
    chk("t5_op_b", bus.op_b, b20);

`ifdef WRITE_VERIFY_EN
    // Corrupted readback sets a sticky error, next start clears it
    corrupt = 1'b1;
    bus.addr_a = 8'd0;
    bus.addr_b = 8'd1;
    bus.addr_c = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (DONE_CYC - 1) tick();
    chk("t6_done", DW'(bus.done), DW'(1));
    chk("t6_verr_done", DW'(bus.verify_err), DW'(1));
    tick();
    chk("t6_verr_sticky", DW'(bus.verify_err), DW'(1));
    corrupt = 1'b0;
    run_op(8'd0, 8'd1, 8'd3, dc);
    chk("t6_verr_clr", DW'(bus.verify_err), '0);
    chk("t6_done_cyc", DW'(dc), DW'(DONE_CYC));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
